// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
// Owner is locked for a burst of up to MAX_BURST beats; wr_en/data_in are registered.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          full,
    input  logic                          almostfull,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic [1:0]                    grant_id,
    output logic                          busy,
    output logic [15:0]                   ack_cnt,
    output logic [7:0]                    drop_cnt
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0] data_in_q, data_in_d;
    logic [15:0]           ack_cnt_q, ack_cnt_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  sel_found;
    logic [ID_W-1:0]       sel_idx;
    logic                  can_write;
    logic [NUM_REQ-1:0]    ready_raw;
    int                    idx;

    // A write already in flight may be the one that fills the FIFO.
    assign can_write = !full && !(almostfull && wr_en_q);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!sel_found && req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = 1'b0;
        data_in_d  = data_in_q;
        ready_raw  = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    state_d    = S_BURST;
                    owner_d    = sel_idx;
                    beat_cnt_d = '0;
                end
            end
            S_BURST: begin
                ready_raw[owner_q] = can_write;
                if (req_valid[owner_q] && can_write) begin
                    wr_en_d    = 1'b1;
                    data_in_d  = req_data[int'(owner_q)*FIFO_WIDTH +: FIFO_WIDTH];
                    beat_cnt_d = beat_cnt_q + BC_W'(1);
                    if (req_last[owner_q] || beat_cnt_q == BC_W'(MAX_BURST - 1)) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = owner_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_cnt_d  = (wr_ack && ack_cnt_q != 16'hFFFF) ? ack_cnt_q + 16'd1 : ack_cnt_q;
        drop_cnt_d = (overflow && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            data_in_q  <= '0;
            ack_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            wr_en_q    <= wr_en_d;
            data_in_q  <= data_in_d;
            ack_cnt_q  <= ack_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign req_ready = rst ? '0 : ready_raw;
    assign wr_en     = wr_en_q;
    assign data_in   = data_in_q;
    assign busy      = (state_q == S_BURST);
    assign grant_id  = busy ? 2'(owner_q) : 2'd0;
    assign ack_cnt   = ack_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        wr_en;
    logic [15:0] data_in;
    logic        full, almostfull, wr_ack, overflow;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] ack_cnt;
    logic [7:0]  drop_cnt;

    int vectors = 0;
    int errors  = 0;

    fifo_wr_arbiter #(.FIFO_WIDTH(16), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en), .data_in(data_in),
        .full(full), .almostfull(almostfull), .wr_ack(wr_ack), .overflow(overflow),
        .grant_id(grant_id), .busy(busy), .ack_cnt(ack_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change just after a rising edge; outputs are checked on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [15:0] d);
        req_data[i*16 +: 16] = d;
    endtask

    task automatic apply_reset();
        cyc();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        full = 1'b0; almostfull = 1'b0; wr_ack = 1'b0; overflow = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; req_last = '0; req_data = '0;
        full = 1'b0; almostfull = 1'b0; wr_ack = 1'b0; overflow = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0000", req_ready); end
        cyc();
        @(negedge clk);
        vectors++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        vectors++; if (data_in !== 16'h0) begin errors++; $display("FAIL reset_data_in: got %h want 0000", data_in); end
        vectors++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL reset_busy_grant: got %b/%0d want 0/0", busy, grant_id); end
        vectors++; if (ack_cnt !== 16'd0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", ack_cnt, drop_cnt); end
        cyc();
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        cyc();
        req_valid = 4'b0100; set_data(2, 16'h00A1);
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("FAIL single_idle: got busy=%b ready=%b want 0/0000", busy, req_ready); end
        cyc();
        @(negedge clk);
        vectors++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got busy=%b grant=%0d want 1/2", busy, grant_id); end
        vectors++; if (req_ready !== 4'b0100 || wr_en !== 1'b0) begin errors++; $display("FAIL single_ready: got ready=%b wr_en=%b want 0100/0", req_ready, wr_en); end
        cyc();
        set_data(2, 16'h00A2);
        @(negedge clk);
        vectors++; if (wr_en !== 1'b1 || data_in !== 16'h00A1) begin errors++; $display("FAIL single_beat1: got %b/%h want 1/00a1", wr_en, data_in); end
        cyc();
        set_data(2, 16'h00A3); req_last = 4'b0100;
        @(negedge clk);
        vectors++; if (wr_en !== 1'b1 || data_in !== 16'h00A2 || busy !== 1'b1) begin errors++; $display("FAIL single_beat2: got %b/%h/%b want 1/00a2/1", wr_en, data_in, busy); end
        cyc();
        req_valid = '0; req_last = '0;
        @(negedge clk);
        vectors++; if (wr_en !== 1'b1 || data_in !== 16'h00A3) begin errors++; $display("FAIL single_beat3: got %b/%h want 1/00a3", wr_en, data_in); end
        vectors++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL single_back_idle: got %b/%0d want 0/0", busy, grant_id); end
        cyc();
        req_valid = 4'b1100;
        @(negedge clk);
        vectors++; if (wr_en !== 1'b0 || data_in !== 16'h00A3) begin errors++; $display("FAIL single_hold: got %b/%h want 0/00a3", wr_en, data_in); end
        cyc();
        req_valid = 4'b0100;
        @(negedge clk);
        vectors++; if (grant_id !== 2'd3 || req_ready !== 4'b1000) begin errors++; $display("FAIL single_rr_next: got grant=%0d ready=%b want 3/1000", grant_id, req_ready); end
        cyc();
        @(negedge clk);
        vectors++; if (busy !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("FAIL single_no_preempt: got %b/%0d want 1/3", busy, grant_id); end
    endtask

    task automatic test_round_robin();
        int owner;
        int prev;
        cyc();
        for (int i = 0; i < 4; i++) set_data(i, 16'h00B0 + 16'(i));
        req_valid = 4'hF;
        prev = 0;
        for (int b = 0; b < 5; b++) begin
            owner = b % 4;
            @(negedge clk);
            vectors++; if (busy !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("FAIL rr_idle_%0d: got %b/%b want 0/0000", b, busy, req_ready); end
            vectors++; if (wr_en !== (b > 0) || (b > 0 && data_in !== 16'h00B0 + 16'(prev))) begin errors++; $display("FAIL rr_idle_wr_%0d: got %b/%h", b, wr_en, data_in); end
            cyc();
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                vectors++; if (busy !== 1'b1 || grant_id !== 2'(owner) || req_ready !== 4'(1 << owner)) begin errors++; $display("FAIL rr_burst_%0d_%0d: got %b/%0d/%b want 1/%0d", b, j, busy, grant_id, req_ready, owner); end
                vectors++; if (wr_en !== (j > 0) || (j > 0 && data_in !== 16'h00B0 + 16'(owner))) begin errors++; $display("FAIL rr_wr_%0d_%0d: got %b/%h", b, j, wr_en, data_in); end
                cyc();
            end
            prev = owner;
        end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || wr_en !== 1'b1 || data_in !== 16'h00B0) begin errors++; $display("FAIL rr_final: got %b/%b/%h want 0/1/00b0", busy, wr_en, data_in); end
    endtask

    task automatic test_backpressure();
        cyc();
        req_valid = 4'b0010; set_data(1, 16'h00C0);
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", busy); end
        cyc();
        @(negedge clk);
        vectors++; if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %0d/%b want 1/0010", grant_id, req_ready); end
        cyc();
        set_data(1, 16'h00C1); full = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 4'h0 || wr_en !== 1'b1 || data_in !== 16'h00C0) begin errors++; $display("FAIL bp_full1: got %b/%b/%h want 0000/1/00c0", req_ready, wr_en, data_in); end
        cyc();
        @(negedge clk);
        vectors++; if (req_ready !== 4'h0 || wr_en !== 1'b0 || data_in !== 16'h00C0) begin errors++; $display("FAIL bp_full2: got %b/%b/%h want 0000/0/00c0", req_ready, wr_en, data_in); end
        cyc();
        full = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0010 || wr_en !== 1'b0) begin errors++; $display("FAIL bp_resume: got %b/%b want 0010/0", req_ready, wr_en); end
        cyc();
        set_data(1, 16'h00C2); req_last = 4'b0010;
        @(negedge clk);
        vectors++; if (wr_en !== 1'b1 || data_in !== 16'h00C1) begin errors++; $display("FAIL bp_beat2: got %b/%h want 1/00c1", wr_en, data_in); end
        cyc();
        req_valid = '0; req_last = '0;
        @(negedge clk);
        vectors++; if (wr_en !== 1'b1 || data_in !== 16'h00C2 || busy !== 1'b0) begin errors++; $display("FAIL bp_beat3: got %b/%h/%b want 1/00c2/0", wr_en, data_in, busy); end
        cyc();
        @(negedge clk);
        vectors++; if (wr_en !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", wr_en); end
    endtask

    task automatic test_almostfull();
        cyc();
        req_valid = 4'b0001; set_data(0, 16'h00D0); almostfull = 1'b1;
        cyc();
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL af_ready_no_wr: got %b want 0001", req_ready); end
        cyc();
        set_data(0, 16'h00D1);
        @(negedge clk);
        vectors++; if (req_ready !== 4'h0 || wr_en !== 1'b1 || data_in !== 16'h00D0) begin errors++; $display("FAIL af_block: got %b/%b/%h want 0000/1/00d0", req_ready, wr_en, data_in); end
        cyc();
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0001 || wr_en !== 1'b0) begin errors++; $display("FAIL af_reopen: got %b/%b want 0001/0", req_ready, wr_en); end
        cyc();
        @(negedge clk);
        vectors++; if (wr_en !== 1'b1 || data_in !== 16'h00D1) begin errors++; $display("FAIL af_beat2: got %b/%h want 1/00d1", wr_en, data_in); end
    endtask

    task automatic test_counters();
        for (int i = 0; i < 300; i++) begin
            cyc();
            wr_ack = 1'b1; overflow = (i < 260);
        end
        cyc();
        wr_ack = 1'b0; overflow = 1'b0;
        @(negedge clk);
        vectors++; if (ack_cnt !== 16'd300) begin errors++; $display("FAIL ack_cnt: got %0d want 300", ack_cnt); end
        vectors++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_cnt_sat: got %0d want 255", drop_cnt); end
    endtask

    task automatic test_reset_midburst();
        cyc();
        req_valid = 4'b0010; set_data(1, 16'h00E0);
        cyc();
        @(negedge clk);
        vectors++; if (grant_id !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL mr_grant: got %0d/%b want 1/1", grant_id, busy); end
        cyc();
        set_data(1, 16'h00E1); rst = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 4'h0 || wr_en !== 1'b1) begin errors++; $display("FAIL mr_during_rst: got %b/%b want 0000/1", req_ready, wr_en); end
        cyc();
        rst = 1'b0; req_valid = 4'b0011;
        @(negedge clk);
        vectors++; if (wr_en !== 1'b0 || data_in !== 16'h0 || busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL mr_outputs: got %b/%h/%b/%0d want 0/0000/0/0", wr_en, data_in, busy, grant_id); end
        vectors++; if (ack_cnt !== 16'd0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL mr_counters: got %0d/%0d want 0/0", ack_cnt, drop_cnt); end
        cyc();
        @(negedge clk);
        vectors++; if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin errors++; $display("FAIL mr_regrant0: got %b/%0d/%b want 1/0/0001", busy, grant_id, req_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        apply_reset();
        test_round_robin();
        apply_reset();
        test_backpressure();
        apply_reset();
        test_almostfull();
        apply_reset();
        test_counters();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width matching the FIFO data_in port.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of write requesters (grant_id width = 2).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_last  input  NUM_REQ  per-requester last beat of burst.
REQ-008 SHALL have port req_data  input  NUM_REQ*FIFO_WIDTH  requester i data at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester beat accepted when valid&ready.
REQ-010 SHALL have port wr_en  output  1  registered FIFO write enable.
REQ-011 SHALL have port data_in  output  FIFO_WIDTH  registered FIFO write data.
REQ-012 SHALL have ports full, almostfull, wr_ack, overflow  input  1 each  FIFO status.
REQ-013 SHALL have port grant_id  output  2  current owner index; 0 when idle.
REQ-014 SHALL have port busy  output  1  high while in BURST.
REQ-015 SHALL have port ack_cnt  output  16  count of wr_ack pulses.
REQ-016 SHALL have port drop_cnt  output  8  count of overflow pulses.

Function
REQ-017 SHALL implement two states: IDLE (no owner) and BURST (owner locked).
REQ-018 SHALL keep rr_ptr; search order is rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
REQ-019 IDLE: if any req_valid, SHALL select the first valid in search order as owner and go to BURST next cycle; req_ready all 0 in IDLE.
REQ-020 SHALL define can_write = !full && !(almostfull && wr_en).
REQ-021 BURST: req_ready[owner] = can_write (combinational); all other req_ready bits 0.
REQ-022 On accepted beat, SHALL register wr_en=1 and data_in=req_data[owner] for exactly the next cycle; otherwise wr_en=0 next cycle, data_in holds.
REQ-023 SHALL count accepted beats in beat_cnt, cleared on entering BURST.
REQ-024 On accepted beat with req_last[owner]=1 or beat_cnt==MAX_BURST-1, SHALL return to IDLE and set rr_ptr=owner.
REQ-025 If owner deasserts req_valid mid-burst, SHALL stay in BURST with owner retained (no preemption).
REQ-026 Write-to-FIFO latency: accepted beat at cycle t -> wr_en high at t+1.
REQ-027 No back-to-back regrant to the same requester while another requester is valid (fairness via REQ-018/024).
REQ-028 ack_cnt SHALL increment on wr_ack and saturate at 16'hFFFF; drop_cnt SHALL increment on overflow and saturate at 8'hFF.
REQ-029 grant_id = owner in BURST, 0 in IDLE; busy = (state==BURST).
REQ-030 req_valid on non-owners in BURST SHALL be ignored; they are considered only at next IDLE.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, rr_ptr=NUM_REQ-1, beat_cnt=0, wr_en=0, data_in=0, grant_id=0, busy=0, ack_cnt=0, drop_cnt=0.
REQ-032 rst mid-burst SHALL abandon the burst; any in-flight wr_en SHALL drop to 0 on the next cycle; req_ready=0 during rst.
REQ-033 First arbitration after reset SHALL favour requester 0.

Verification
REQ-034 Single requester: req_valid[2]=1, 3 beats 0xA1,0xA2,0xA3 with req_last on third -> IDLE 1 cycle, BURST, wr_en high 3 cycles with those data, grant_id=2, then IDLE, rr_ptr=2.
REQ-035 All four valid continuously, no req_last -> bursts of exactly 4 beats, owner order 0,1,2,3,0; one idle cycle between bursts.
REQ-036 Backpressure: full=1 during BURST -> req_ready[owner]=0, wr_en=0; full drops -> beats resume, no data lost or duplicated.
REQ-037 almostfull=1 with wr_en=1 -> req_ready[owner]=0 that cycle; almostfull=1 with wr_en=0 -> req_ready[owner]=1.
REQ-038 Drive 300 wr_ack pulses and 260 overflow pulses -> ack_cnt=300, drop_cnt=255 (saturated).
REQ-039 Assert rst during beat 2 of a burst by requester 1 -> next cycle all outputs at reset values; next grant goes to requester 0 if valid.
